uart_tx_engine: RTL and testbench

UART_TX_ENGINE -- requirements
Module: uart_tx_engine

---
 rtl/uart_tx_engine.sv | 114 +++++++++++
 tb/tb_uart_tx_engine.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_engine.sv
// UART transmit engine: pulls bytes from a TX FIFO and serialises them as
// start / 8 data (LSB first) / optional parity / 1-2 stop bits, plus an idle gap.
module uart_tx_engine (
    input  logic       clk,
    input  logic       rst_,
    input  logic       txrst,
    input  logic [9:0] baud_div,
    input  logic       check,
    input  logic       parity,
    input  logic       stop_bit,
    input  logic [3:0] two_tx_delay,
    input  logic [7:0] fifo_rdata,
    input  logic       fifo_rempty,
    output logic       fifo_rinc,
    output logic       txd,
    output logic       tx_busy
);

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PAR, STOP, GAP} state_t;

    state_t     state, state_d;
    logic [9:0] period_q, cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] per_q, per_d;
    logic [7:0] data_q;
    logic       check_q, odd_q, stop2_q;
    logic [3:0] delay_q;
    logic       bit_done;
    logic       txd_d, busy_d, rinc_d;

    assign bit_done = (cnt_q == period_q - 10'd1);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state     <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            per_q     <= '0;
            period_q  <= '0;
            data_q    <= '0;
            check_q   <= 1'b0;
            odd_q     <= 1'b0;
            stop2_q   <= 1'b0;
            delay_q   <= '0;
            txd       <= 1'b1;
            tx_busy   <= 1'b0;
            fifo_rinc <= 1'b0;
        end else begin
            state     <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            per_q     <= per_d;
            txd       <= txd_d;
            tx_busy   <= busy_d;
            fifo_rinc <= rinc_d;
            if (state == LOAD) begin
                data_q   <= fifo_rdata;
                check_q  <= check;
                odd_q    <= parity;
                stop2_q  <= stop_bit;
                delay_q  <= two_tx_delay;
                period_q <= (baud_div < 10'd2) ? 10'd2 : baud_div;
            end
        end
    end

    always_comb begin
        state_d = state;
        if (txrst) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE:  if (fifo_rinc) state_d = LOAD;
                LOAD:  state_d = START;
                START: if (bit_done) state_d = DATA;
                DATA:  if (bit_done && idx_q == 3'd7) state_d = check_q ? PAR : STOP;
                PAR:   if (bit_done) state_d = STOP;
                STOP:  if (bit_done && per_q == {3'b000, stop2_q})
                           state_d = (delay_q != 4'd0) ? GAP : IDLE;
                GAP:   if (bit_done && per_q == delay_q - 4'd1) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // per_q counts whole bit periods inside STOP and GAP
        if (state_d != state || state == IDLE || state == LOAD) begin
            cnt_d = '0;
            per_d = '0;
        end else begin
            cnt_d = bit_done ? '0 : cnt_q + 10'd1;
            per_d = bit_done ? per_q + 4'd1 : per_q;
        end

        if (state_d != DATA)
            idx_d = '0;
        else if (state == DATA && bit_done)
            idx_d = idx_q + 3'd1;
        else
            idx_d = idx_q;
    end

    // Outputs are derived from the next state so they can be registered with no added latency.
    always_comb begin
        busy_d = (state_d != IDLE);
        rinc_d = (state_d == IDLE) && !fifo_rempty && !txrst;
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = data_q[idx_d];
            PAR:     txd_d = (^data_q) ^ odd_q;
            default: txd_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: FIFO model plus frame scoreboard,
// checks bit timing, parity, gaps, abort and reset behaviour.
module tb_uart_tx_engine;

    logic       clk = 1'b0;
    logic       rst_;
    logic       txrst;
    logic [9:0] baud_div;
    logic       check;
    logic       parity;
    logic       stop_bit;
    logic [3:0] two_tx_delay;
    logic [7:0] fifo_rdata = 8'h00;
    logic       fifo_rempty = 1'b1;
    logic       fifo_rinc;
    logic       txd;
    logic       tx_busy;

    uart_tx_engine dut (
        .clk(clk), .rst_(rst_), .txrst(txrst), .baud_div(baud_div),
        .check(check), .parity(parity), .stop_bit(stop_bit),
        .two_tx_delay(two_tx_delay), .fifo_rdata(fifo_rdata),
        .fifo_rempty(fifo_rempty), .fifo_rinc(fifo_rinc),
        .txd(txd), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       chk;
        logic       odd;
        logic       two;
        int         p;
    } sb_t;

    logic [7:0] fq[$];
    sb_t        sb[$];

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int rinc_cnt = 0, rinc_cyc = 0, proto_err = 0;
    int busy_rise = 0, busy_fall = 0;
    logic rinc_prev = 1'b0, busy_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk)
        if (fifo_rinc && fq.size() > 0) fifo_rdata <= fq.pop_front();

    always @(negedge clk) begin
        if (fifo_rinc) begin
            rinc_cnt++;
            rinc_cyc = cyc;
            if (tx_busy || rinc_prev) proto_err++;
        end
        if (tx_busy && !busy_prev) busy_rise = cyc;
        if (!tx_busy && busy_prev) busy_fall = cyc;
        rinc_prev = fifo_rinc;
        busy_prev = tx_busy;
        fifo_rempty <= (fq.size() == 0);
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic push_byte(input logic [7:0] b);
        sb_t e;
        e.data = b;
        e.chk  = check;
        e.odd  = parity;
        e.two  = stop_bit;
        e.p    = (baud_div < 10'd2) ? 2 : int'(baud_div);
        fq.push_back(b);
        sb.push_back(e);
    endtask

    task automatic wait_start(output int s);
        s = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (txd === 1'b0) begin
                s = cyc;
                break;
            end
        end
        chk("start_seen", int'(s >= 0), 1);
    endtask

    // Entered at the negedge of the first start-bit cycle.
    task automatic check_frame(input sb_t e, input string name);
        logic [12:0] bits;
        int n, good, busy_ok;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = e.data[i];
        n = 9;
        if (e.chk) begin
            bits[n] = e.odd ? ~(^e.data) : ^e.data;
            n++;
        end
        n = n + 1 + int'(e.two);
        busy_ok = 0;
        for (int b = 0; b < n; b++) begin
            good = 0;
            for (int j = 0; j < e.p; j++) begin
                if (!(b == 0 && j == 0)) @(negedge clk);
                if (txd === bits[b]) good++;
                if (tx_busy === 1'b1) busy_ok++;
            end
            chk($sformatf("%s_bit%0d", name, b), good, e.p);
        end
        chk($sformatf("%s_busy", name), busy_ok, n * e.p);
    endtask

    task automatic recv(input string name);
        sb_t e;
        int s;
        e = sb.pop_front();
        wait_start(s);
        chk($sformatf("%s_latency", name), s - rinc_cyc, 2);
        check_frame(e, name);
    endtask

    initial begin
        sb_t e;
        int s, s0, s1, s2, r0, hi, found;
        logic [7:0] dropped;

        rst_ = 1'b0; txrst = 1'b0; baud_div = 10'd4; check = 1'b0;
        parity = 1'b0; stop_bit = 1'b0; two_tx_delay = 4'd0;
        #12;
        chk("reset_txd", int'(txd), 1);
        chk("reset_busy", int'(tx_busy), 0);
        chk("reset_rinc", int'(fifo_rinc), 0);
        @(negedge clk);
        rst_ = 1'b1;

        // Empty FIFO: line stays idle, no reads
        r0 = rinc_cnt; hi = 0;
        repeat (100) begin
            @(negedge clk);
            if (txd === 1'b1) hi++;
        end
        chk("empty_txd_high", hi, 100);
        chk("empty_no_rinc", rinc_cnt - r0, 0);

        // Basic frame 0xA5, P=4
        push_byte(8'hA5);
        recv("basic");
        repeat (3) @(negedge clk);
        chk("basic_busy_len", busy_fall - busy_rise, 41);

        // Parity even then odd with two stop bits, P=3
        baud_div = 10'd3; check = 1'b1; parity = 1'b0;
        push_byte(8'h07);
        recv("par_even");
        parity = 1'b1; stop_bit = 1'b1;
        push_byte(8'h07);
        recv("par_odd");
        repeat (3) @(negedge clk);
        chk("par_odd_busy_len", busy_fall - busy_rise, 37);

        // Config changes after the frame starts must not affect it
        baud_div = 10'd5; check = 1'b1; parity = 1'b1; stop_bit = 1'b1;
        push_byte(8'h3C);
        e = sb.pop_front();
        wait_start(s);
        baud_div = 10'd9; check = 1'b0; parity = 1'b0; stop_bit = 1'b0;
        check_frame(e, "cfg_hold");

        // Back-to-back with gap
        baud_div = 10'd2; check = 1'b0; stop_bit = 1'b0; two_tx_delay = 4'd3;
        repeat (5) @(negedge clk);
        r0 = rinc_cnt;
        push_byte(8'h01); push_byte(8'h80); push_byte(8'hFF);
        e = sb.pop_front(); wait_start(s0); check_frame(e, "b2b0");
        e = sb.pop_front(); wait_start(s1); check_frame(e, "b2b1");
        e = sb.pop_front(); wait_start(s2); check_frame(e, "b2b2");
        chk("b2b_space01", s1 - s0, 28);
        chk("b2b_space12", s2 - s1, 28);
        repeat (20) @(negedge clk);
        chk("b2b_rinc_count", rinc_cnt - r0, 3);

        // baud_div below 2 is clamped
        two_tx_delay = 4'd0; baud_div = 10'd0;
        push_byte(8'h5A);
        recv("clamp");
        repeat (3) @(negedge clk);
        chk("clamp_busy_len", busy_fall - busy_rise, 21);

        // txrst during DATA bit 3
        baud_div = 10'd4;
        push_byte(8'hC3); push_byte(8'h96);
        e = sb.pop_front();
        wait_start(s);
        repeat (17) @(negedge clk);
        txrst = 1'b1;
        @(negedge clk);
        chk("abort_txd", int'(txd), 1);
        chk("abort_busy", int'(tx_busy), 0);
        txrst = 1'b0;
        recv("after_abort");

        // txrst coinciding with the read strobe drops the popped byte
        repeat (4) @(negedge clk);
        push_byte(8'h11); push_byte(8'h22);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fifo_rinc === 1'b1) begin
                found = 1;
                break;
            end
        end
        chk("drop_rinc_seen", found, 1);
        txrst = 1'b1;
        @(negedge clk);
        chk("drop_busy", int'(tx_busy), 0);
        chk("drop_rinc_low", int'(fifo_rinc), 0);
        txrst = 1'b0;
        dropped = sb.pop_front().data;
        recv("after_drop");

        // Async reset during STOP
        repeat (4) @(negedge clk);
        push_byte(8'hE7);
        e = sb.pop_front();
        wait_start(s);
        repeat (37) @(negedge clk);
        #1 rst_ = 1'b0;
        #1;
        chk("areset_txd", int'(txd), 1);
        chk("areset_busy", int'(tx_busy), 0);
        repeat (3) @(negedge clk);
        rst_ = 1'b1;
        r0 = rinc_cnt; hi = 0;
        repeat (20) begin
            @(negedge clk);
            if (txd === 1'b1) hi++;
        end
        chk("areset_idle_txd", hi, 20);
        chk("areset_no_rinc", rinc_cnt - r0, 0);
        push_byte(8'h3A);
        recv("after_areset");

        repeat (5) @(negedge clk);
        chk("rinc_protocol", proto_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
